// File: rtl/fpu_rt_sched_pkg.sv
// Shared constants for the FP sqrt/div scheduler.
// Unit count, result latency, shadow length and op-field codes.
package fpu_rt_sched_pkg;

    localparam int NUM_UNITS  = 3;
    localparam int DATA_DLY   = 5;
    localparam int SHADOW_LEN = 3;
    localparam int OP_W       = 13;
    localparam int II_W       = 10;
    localparam int REG_W      = 9;

    localparam logic [OP_W-1:0] fop_div   = 13'h0020;
    localparam logic [OP_W-1:0] fop_divs  = 13'h0021;
    localparam logic [OP_W-1:0] fop_sqrt  = 13'h0040;
    localparam logic [OP_W-1:0] fop_sqrts = 13'h0041;

endpackage

// File: rtl/fpu_rt_sched_rr_arb.sv
// Round-robin one-hot arbiter; search starts one past the last grantee.
// Pointer resets to N-1 so index 0 is searched first.
module rr_arb_onehot #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] nextPtr;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant   = '0;
        nextPtr = ptr;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                nextPtr    = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr <= PW'(N - 1);
        else      ptr <= nextPtr;
    end

endmodule

// File: rtl/fpu_rt_sched.sv
// Scheduler for the iterative root/divide units: request buffer,
// dispatch with start shadow, round-robin writeback and data steering.
module fpu_rt_sched
    import fpu_rt_sched_pkg::*;
#(
    parameter int NU   = NUM_UNITS,
    parameter int OPW  = OP_W,
    parameter int IIW  = II_W,
    parameter int RW   = REG_W,
    parameter int DDLY = DATA_DLY
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           except,
    input  logic           req_en,
    input  logic [OPW-1:0] req_op,
    input  logic [IIW-1:0] req_II,
    input  logic [RW-1:0]  req_reg,
    output logic           req_pause,
    input  logic [NU-1:0]  unit_rdy,
    output logic [NU-1:0]  unit_start,
    output logic [OPW-1:0] start_op,
    output logic [IIW-1:0] start_II,
    output logic [RW-1:0]  start_reg,
    input  logic [NU-1:0]  unit_done,
    output logic [NU-1:0]  unit_grant,
    output logic           wb_en,
    output logic [NU-1:0]  wb_sel,
    output logic           wb_zero,
    output logic [NU-1:0]  busy
);

    localparam int EW = OPW + IIW + RW;
    localparam int SW = $clog2(SHADOW_LEN + 1);

    logic [EW-1:0] fifoMem [2];
    logic          rdPtr;
    logic          wrPtr;
    logic [1:0]    count;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    logic [SW-1:0] shadow [NU];
    logic [NU-1:0] shadowOn;
    logic [NU-1:0] elig;
    logic [NU-1:0] startVec;
    logic [NU-1:0] selPipe [DDLY];

    assign req_pause = (count == 2'd2);
    assign push      = req_en & ~req_pause & ~except;
    assign head      = fifoMem[rdPtr];

    always_comb begin
        shadowOn = '0;
        for (int n = 0; n < NU; n++) shadowOn[n] = (shadow[n] != '0);
    end

    // lowest-index eligible unit; start_* come only from the registered head
    assign elig     = unit_rdy & ~shadowOn;
    assign startVec = (count != 2'd0 && !except) ? (elig & (~elig + NU'(1))) : '0;
    assign pop      = |startVec;

    assign unit_start = startVec;
    assign {start_op, start_II, start_reg} = pop ? head : '0;
    assign busy = ~unit_rdy | shadowOn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= 2'd0;
            rdPtr      <= 1'b0;
            wrPtr      <= 1'b0;
            fifoMem[0] <= '0;
            fifoMem[1] <= '0;
        end else if (except) begin
            count <= 2'd0;
            rdPtr <= 1'b0;
            wrPtr <= 1'b0;
        end else begin
            if (push) begin
                fifoMem[wrPtr] <= {req_op, req_II, req_reg};
                wrPtr          <= ~wrPtr;
            end
            if (pop) rdPtr <= ~rdPtr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < NU; n++) shadow[n] <= '0;
        end else begin
            for (int n = 0; n < NU; n++) begin
                if (startVec[n])        shadow[n] <= SW'(SHADOW_LEN);
                else if (shadowOn[n])   shadow[n] <= shadow[n] - SW'(1);
            end
        end
    end

    rr_arb_onehot #(.N(NU)) uArb (
        .clk   (clk),
        .rst   (rst),
        .req   (unit_done),
        .grant (unit_grant)
    );

    assign wb_en = |unit_grant;

    // keeps shifting through a flush so in-flight results still land
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DDLY; i++) selPipe[i] <= '0;
        end else begin
            selPipe[0] <= unit_grant;
            for (int i = 1; i < DDLY; i++) selPipe[i] <= selPipe[i-1];
        end
    end

    assign wb_sel  = selPipe[DDLY-1];
    assign wb_zero = ~|wb_sel;

    assert property (@(posedge clk) disable iff (!rst)
        !(req_en && req_pause && !except));

endmodule

// File: tb/tb_fpu_rt_sched.sv
// Scoreboard bench for fpu_rt_sched: stimulus queues expectations,
// a negedge monitor pops them when starts, grants or wb_sel appear.
module tb_fpu_rt_sched;

    localparam int DDLY = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        except = 1'b0;
    logic        req_en = 1'b0;
    logic [12:0] req_op = '0;
    logic [9:0]  req_II = '0;
    logic [8:0]  req_reg = '0;
    logic [2:0]  unit_rdy = 3'b111;
    logic [2:0]  unit_done = 3'b000;
    logic        req_pause;
    logic [2:0]  unit_start;
    logic [12:0] start_op;
    logic [9:0]  start_II;
    logic [8:0]  start_reg;
    logic [2:0]  unit_grant;
    logic        wb_en;
    logic [2:0]  wb_sel;
    logic        wb_zero;
    logic [2:0]  busy;

    fpu_rt_sched dut (
        .clk        (clk),
        .rst        (rst),
        .except     (except),
        .req_en     (req_en),
        .req_op     (req_op),
        .req_II     (req_II),
        .req_reg    (req_reg),
        .req_pause  (req_pause),
        .unit_rdy   (unit_rdy),
        .unit_start (unit_start),
        .start_op   (start_op),
        .start_II   (start_II),
        .start_reg  (start_reg),
        .unit_done  (unit_done),
        .unit_grant (unit_grant),
        .wb_en      (wb_en),
        .wb_sel     (wb_sel),
        .wb_zero    (wb_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  u;
        logic [12:0] op;
        logic [9:0]  ii;
        logic [8:0]  rg;
    } startExp_t;

    typedef struct {
        logic [2:0] s;
        int         due;
    } selExp_t;

    startExp_t  startQ [$];
    logic [2:0] grantQ [$];
    selExp_t    selQ [$];

    int nVec = 0;
    int nBad = 0;
    int cyc = 0;

    startExp_t  se;
    logic [2:0] ge;
    selExp_t    sl;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [12:0] op, input logic [9:0] ii,
                         input logic [8:0] rg, input logic [2:0] u);
        req_en  = 1'b1;
        req_op  = op;
        req_II  = ii;
        req_reg = rg;
        if (u != 3'b000) startQ.push_back('{u, op, ii, rg});
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (unit_start != 3'b000) begin
            if (startQ.size() == 0) begin
                check("start_unexpected", 32'(unit_start), 32'h0);
            end else begin
                se = startQ.pop_front();
                check("start_unit", 32'(unit_start), 32'(se.u));
                check("start_op", 32'(start_op), 32'(se.op));
                check("start_II", 32'(start_II), 32'(se.ii));
                check("start_reg", 32'(start_reg), 32'(se.rg));
            end
        end
        if (unit_grant != 3'b000) begin
            if (grantQ.size() == 0) begin
                check("grant_unexpected", 32'(unit_grant), 32'h0);
            end else begin
                ge = grantQ.pop_front();
                check("grant", 32'(unit_grant), 32'(ge));
                check("wb_en", 32'(wb_en), 32'h1);
                selQ.push_back('{ge, cyc + DDLY});
            end
        end
        if (wb_sel != 3'b000) begin
            if (selQ.size() == 0) begin
                check("wb_sel_unexpected", 32'(wb_sel), 32'h0);
            end else begin
                sl = selQ.pop_front();
                check("wb_sel", 32'(wb_sel), 32'(sl.s));
                check("wb_sel_cycle", 32'(cyc), 32'(sl.due));
                check("wb_zero_window", 32'(wb_zero), 32'h0);
            end
        end
    end

    initial begin
        #12;
        check("rst_start", 32'(unit_start), 32'h0);
        check("rst_grant", 32'(unit_grant), 32'h0);
        check("rst_wb_en", 32'(wb_en), 32'h0);
        check("rst_wb_sel", 32'(wb_sel), 32'h0);
        check("rst_wb_zero", 32'(wb_zero), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_pause", 32'(req_pause), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // single request, then its writeback
        issue(13'h0040, 10'h011, 9'h021, 3'b001);
        step();
        req_en = 1'b0;
        step();
        unit_rdy = 3'b110;
        #1;
        check("busy0", 32'(busy[0]), 32'h1);
        unit_done = 3'b001;
        grantQ.push_back(3'b001);
        step();
        unit_done = 3'b000;
        unit_rdy = 3'b111;
        repeat (8) step();

        // back-to-back requests, fill the buffer
        issue(13'h0101, 10'h101, 9'h0a1, 3'b001);
        step();
        issue(13'h0102, 10'h102, 9'h0a2, 3'b010);
        step();
        unit_rdy = 3'b110;
        issue(13'h0103, 10'h103, 9'h0a3, 3'b100);
        step();
        unit_rdy = 3'b100;
        issue(13'h0104, 10'h104, 9'h0a4, 3'b010);
        step();
        unit_rdy = 3'b000;
        issue(13'h0105, 10'h105, 9'h0a5, 3'b001);
        step();
        req_en = 1'b0;
        check("pause_full", 32'(req_pause), 32'h1);
        unit_rdy = 3'b010;
        #1;
        check("shadow_hold", 32'(unit_start), 32'h0);
        step();
        check("pause_still", 32'(req_pause), 32'h1);
        step();
        unit_rdy = 3'b001;
        #1;
        check("pause_drop", 32'(req_pause), 32'h0);
        step();
        unit_rdy = 3'b111;
        repeat (4) step();

        // shadow keeps a still-ready unit ineligible for 3 cycles
        issue(13'h0201, 10'h201, 9'h0b1, 3'b001);
        step();
        issue(13'h0202, 10'h202, 9'h0b2, 3'b010);
        step();
        req_en = 1'b0;
        step();
        issue(13'h0203, 10'h203, 9'h0b3, 3'b100);
        step();
        issue(13'h0204, 10'h204, 9'h0b4, 3'b001);
        step();
        req_en = 1'b0;
        repeat (4) step();

        // flush with two queued plus a simultaneous request
        unit_rdy = 3'b000;
        issue(13'h0301, 10'h301, 9'h0c1, 3'b000);
        step();
        issue(13'h0302, 10'h302, 9'h0c2, 3'b000);
        step();
        check("pause_pre_flush", 32'(req_pause), 32'h1);
        issue(13'h0303, 10'h303, 9'h0c3, 3'b000);
        except = 1'b1;
        unit_rdy = 3'b111;
        #1;
        check("flush_no_start", 32'(unit_start), 32'h0);
        step();
        except = 1'b0;
        req_en = 1'b0;
        #1;
        check("flush_pause", 32'(req_pause), 32'h0);
        check("flush_empty", 32'(unit_start), 32'h0);
        repeat (4) step();

        // async reset mid-dispatch
        issue(13'h0401, 10'h401, 9'h0d1, 3'b000);
        step();
        req_en = 1'b0;
        check("pre_rst_start", 32'(unit_start), 32'h1);
        rst = 1'b0;
        #1;
        check("arst_start", 32'(unit_start), 32'h0);
        check("arst_op", 32'(start_op), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_wb_en", 32'(wb_en), 32'h0);
        check("arst_wb_zero", 32'(wb_zero), 32'h1);
        check("arst_pause", 32'(req_pause), 32'h0);
        repeat (2) step();
        rst = 1'b1;
        step();

        // all units done: rotating grants starting at unit 0
        unit_done = 3'b111;
        grantQ.push_back(3'b001);
        grantQ.push_back(3'b010);
        grantQ.push_back(3'b100);
        grantQ.push_back(3'b001);
        repeat (4) step();
        unit_done = 3'b000;
        repeat (10) step();

        check("startQ_drained", 32'(startQ.size()), 32'h0);
        check("grantQ_drained", 32'(grantQ.size()), 32'h0);
        check("selQ_drained", 32'(selQ.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
